// File: rtl/usb_utm_tx_nrzi.sv
// UTMI full-speed transmit engine: SYNC, bit stuffing, NRZI, EOP and line drive.
// Line outputs are registered one cycle behind the bit-slot state machine.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | line J, no drive; waits for tx_valid
// S_SYNC    | shifting the 8'h80 SYNC pattern
// S_DATA    | shifting packet bytes, refilled from the holding register
// S_ABORT   | underrun: eight unstuffed ones to force a stuff error
// S_EOP_SE0 | SE0 for EOP_SE0_BITS bit times
// S_EOP_J   | one J bit time, then release the line
module usb_utm_tx_nrzi #(
   parameter int CLK_PER_BIT  = 4,
   parameter int STUFF_LIMIT  = 6,
   parameter int EOP_SE0_BITS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       suspend_m,
   input  logic [1:0] op_mode,
   input  logic [7:0] data_in,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       dp_tx,
   output logic       dn_tx,
   output logic       tx_oen,
   output logic       tx_busy
);

   localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam int OW = $clog2(STUFF_LIMIT + 1);
   localparam int LW = ($clog2(EOP_SE0_BITS + 1) > 4) ? $clog2(EOP_SE0_BITS + 1) : 4;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);
   localparam logic [OW-1:0] ONES_PRE  = OW'(STUFF_LIMIT - 1);
   localparam logic [OW-1:0] ONES_INC  = OW'(1);
   localparam logic [LW-1:0] LEFT_BYTE = LW'(8);
   localparam logic [LW-1:0] LEFT_SE0  = LW'(EOP_SE0_BITS);
   localparam logic [LW-1:0] LEFT_ONE  = LW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_DATA, S_ABORT, S_EOP_SE0, S_EOP_J
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   bit_cnt;
   logic [7:0]      shreg;
   logic [LW-1:0]   bits_left;
   logic [OW-1:0]   ones_cnt;
   logic            lvl;
   logic [7:0]      hold;
   logic            hold_full;
   logic            raw;

   logic tick, in_bits, stuff_en, stuff_slot, cur_bit, line_bit, byte_end;
   logic accept, line_dp, line_dn;

   assign tick       = (bit_cnt == '0);
   assign in_bits    = (state == S_SYNC) || (state == S_DATA) || (state == S_ABORT);
   assign stuff_en   = !raw && (state != S_ABORT);
   assign stuff_slot = stuff_en && (ones_cnt == ONES_MAX);
   assign cur_bit    = stuff_slot ? 1'b0 : shreg[0];
   assign line_bit   = raw ? cur_bit : (cur_bit ? lvl : ~lvl);

   // A byte is finished only after any stuff bit owed to its last one.
   assign byte_end = stuff_slot ? (bits_left == '0)
                   : ((bits_left == LEFT_ONE) && !(stuff_en && shreg[0] && (ones_cnt == ONES_PRE)));

   // Held low on the boundary cycle itself so a late byte cannot race the refill.
   assign tx_ready = ((state == S_SYNC) || (state == S_DATA)) && !hold_full && !(tick && byte_end);
   assign accept   = tx_valid && tx_ready;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:
            if (tx_valid && suspend_m && (op_mode != 2'b01) && !tx_busy) state_nx = S_SYNC;
         S_SYNC, S_DATA:
            if (tick && byte_end) begin
               if (hold_full)     state_nx = S_DATA;
               else if (tx_valid) state_nx = S_ABORT;
               else               state_nx = S_EOP_SE0;
            end
         S_ABORT:
            if (tick && byte_end) state_nx = S_EOP_SE0;
         S_EOP_SE0:
            if (tick && (bits_left == LEFT_ONE)) state_nx = S_EOP_J;
         S_EOP_J:
            if (tick) state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      line_dp = 1'b1;
      line_dn = 1'b0;
      case (state)
         S_SYNC, S_DATA, S_ABORT: begin
            line_dp = line_bit;
            line_dn = ~line_bit;
         end
         S_EOP_SE0: begin
            line_dp = 1'b0;
            line_dn = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         bit_cnt   <= BIT_LAST;
         shreg     <= '0;
         bits_left <= '0;
         ones_cnt  <= '0;
         lvl       <= 1'b1;
         hold      <= '0;
         hold_full <= 1'b0;
         raw       <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            hold      <= data_in;
            hold_full <= 1'b1;
         end
         if (state == S_IDLE) begin
            bit_cnt   <= BIT_LAST;
            lvl       <= 1'b1;
            ones_cnt  <= '0;
            hold_full <= 1'b0;
            if (state_nx == S_SYNC) begin
               shreg     <= 8'h80;
               bits_left <= LEFT_BYTE;
               raw       <= (op_mode == 2'b10);
            end
         end else begin
            bit_cnt <= tick ? BIT_LAST : bit_cnt - 1'b1;
            if (tick && in_bits) begin
               if (!raw) lvl <= line_bit;
               if (stuff_slot) begin
                  ones_cnt <= '0;
               end else begin
                  shreg     <= {1'b0, shreg[7:1]};
                  bits_left <= bits_left - LEFT_ONE;
                  if (stuff_en) ones_cnt <= shreg[0] ? ones_cnt + ONES_INC : '0;
               end
               if (byte_end) begin
                  case (state_nx)
                     S_DATA: begin
                        shreg     <= hold;
                        bits_left <= LEFT_BYTE;
                        hold_full <= 1'b0;
                     end
                     S_ABORT: begin
                        shreg     <= 8'hFF;
                        bits_left <= LEFT_BYTE;
                     end
                     S_EOP_SE0: bits_left <= LEFT_SE0;
                     default: ;
                  endcase
               end
            end else if (tick && (state == S_EOP_SE0)) begin
               bits_left <= bits_left - LEFT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_tx   <= 1'b1;
         dn_tx   <= 1'b0;
         tx_oen  <= 1'b0;
         tx_busy <= 1'b0;
      end else begin
         dp_tx   <= line_dp;
         dn_tx   <= line_dn;
         tx_oen  <= (state != S_IDLE);
         tx_busy <= (state != S_IDLE) || (state_nx != S_IDLE);
      end
   end

endmodule

// File: tb/tb_usb_utm_tx_nrzi.sv
// Bench for usb_utm_tx_nrzi: table of packets checked cycle by cycle against a
// line-level scoreboard, plus hand sequences for reset, non-driving and suspend.
module tb_usb_utm_tx_nrzi;
   localparam int CPB   = 4;
   localparam int STUFF = 6;
   localparam int SE0B  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       suspend_m = 1'b1;
   logic [1:0] op_mode = 2'b00;
   logic [7:0] data_in = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, dp_tx, dn_tx, tx_oen, tx_busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   usb_utm_tx_nrzi #(
      .CLK_PER_BIT (CPB),
      .STUFF_LIMIT (STUFF),
      .EOP_SE0_BITS(SE0B)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .suspend_m(suspend_m),
      .op_mode  (op_mode),
      .data_in  (data_in),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .dp_tx    (dp_tx),
      .dn_tx    (dn_tx),
      .tx_oen   (tx_oen),
      .tx_busy  (tx_busy)
   );

   typedef struct {
      logic [23:0] bytes;     // byte 0 in [7:0]
      int          n;
      bit          raw;
      bit          underrun;
      int          exp_bits;  // line bit times while tx_oen is high
   } vec_t;

   vec_t       vecs [10];
   logic [3:0] exp_q [$];     // {busy, oen, dp, dn} per cycle
   int         eop_idx;
   logic       m_lvl;
   bit         m_raw;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic emit_bit(input logic b);
      logic line;
      line  = m_raw ? b : (b ? m_lvl : ~m_lvl);
      m_lvl = line;
      repeat (CPB) exp_q.push_back({2'b11, line, ~line});
   endtask

   task automatic build_exp(input vec_t v);
      logic [7:0] cur;
      int ones;
      exp_q.delete();
      m_lvl = 1'b1;
      m_raw = v.raw;
      ones  = 0;
      for (int k = 0; k <= v.n; k++) begin
         cur = (k == 0) ? 8'h80 : v.bytes[8*(k-1) +: 8];
         for (int j = 0; j < 8; j++) begin
            emit_bit(cur[j]);
            if (!v.raw) begin
               ones = cur[j] ? ones + 1 : 0;
               if (ones == STUFF) begin
                  emit_bit(1'b0);
                  ones = 0;
               end
            end
         end
      end
      eop_idx = exp_q.size();
      if (v.underrun) repeat (8) emit_bit(1'b1);
      repeat (SE0B * CPB) exp_q.push_back(4'b1100);
      repeat (CPB) exp_q.push_back(4'b1110);
      exp_q.push_back(4'b0010);
   endtask

   // Called at a negedge with the DUT idle and tx_busy low.
   task automatic run_vec(input vec_t v, input int vn);
      int bi, acc, oen_cyc, bad_rdy, first_bad, len;
      bit pend;
      logic [3:0] smp, e, bad_act, bad_exp;
      build_exp(v);
      len = exp_q.size();
      bi = 0; acc = 0; oen_cyc = 0; bad_rdy = 0; first_bad = -1;
      bad_act = '0; bad_exp = '0;
      op_mode  = v.raw ? 2'b10 : 2'b00;
      data_in  = v.bytes[7:0];
      tx_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_start_busy_oen", vn), int'({tx_busy, tx_oen}), 2);
      op_mode = 2'b00;
      pend = tx_valid && tx_ready;
      for (int idx = 0; idx < len; idx++) begin
         @(negedge clk);
         if (pend) begin
            acc++;
            bi++;
            if (bi < v.n) data_in = v.bytes[8*bi +: 8];
            else tx_valid = 1'b0;
         end
         if (v.underrun && idx == eop_idx - 2) tx_valid = 1'b1;
         if (v.underrun && idx == eop_idx + 8 * CPB - 1) tx_valid = 1'b0;
         smp = {tx_busy, tx_oen, dp_tx, dn_tx};
         e   = exp_q.pop_front();
         if (smp !== e && first_bad < 0) begin
            first_bad = idx;
            bad_act   = smp;
            bad_exp   = e;
         end
         if (tx_oen) oen_cyc++;
         if (idx >= eop_idx - 1 && tx_ready) bad_rdy++;
         pend = tx_valid && tx_ready;
      end
      checks++;
      if (first_bad >= 0) begin
         failures++;
         $display("FAIL vec%0d_line cycle %0d actual {busy,oen,dp,dn}=%b required=%b",
                  vn, first_bad, bad_act, bad_exp);
      end
      check($sformatf("vec%0d_oen_cycles", vn), oen_cyc, v.exp_bits * CPB);
      if (!v.underrun) check($sformatf("vec%0d_accepts", vn), acc, v.n);
      check($sformatf("vec%0d_ready_after_data", vn), bad_rdy, 0);
   endtask

   initial begin
      int cnt;
      vecs[0] = '{24'h000000, 1, 1'b0, 1'b0, 19};
      vecs[1] = '{24'h0000FF, 1, 1'b0, 1'b0, 20};
      vecs[2] = '{24'h0000FF, 1, 1'b1, 1'b0, 19};
      vecs[3] = '{24'h00000F, 1, 1'b0, 1'b0, 19};
      vecs[4] = '{24'h00001F, 1, 1'b0, 1'b0, 20};
      vecs[5] = '{24'h00FFFF, 2, 1'b0, 1'b0, 29};
      vecs[6] = '{24'h00FFFF, 2, 1'b1, 1'b0, 27};
      vecs[7] = '{24'hC33CA5, 3, 1'b0, 1'b0, 35};
      vecs[8] = '{24'h0000FC, 1, 1'b0, 1'b0, 20};
      vecs[9] = '{24'h000000, 1, 1'b0, 1'b1, 27};

      @(negedge clk);
      check("reset_outputs", int'({dp_tx, dn_tx, tx_oen, tx_ready, tx_busy}), 5'b10000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      op_mode  = 2'b01;
      tx_valid = 1'b1;
      cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx_oen || tx_ready || tx_busy) cnt++;
      end
      check("nondriving_quiet_cycles", cnt, 0);
      tx_valid = 1'b0;
      op_mode  = 2'b00;

      suspend_m = 1'b0;
      tx_valid  = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_busy || tx_oen) cnt++;
      end
      check("suspend_blocks_start", cnt, 0);
      tx_valid  = 1'b0;
      suspend_m = 1'b1;
      @(negedge clk);

      data_in  = 8'h00;
      tx_valid = 1'b1;
      repeat (2) @(negedge clk);
      tx_valid = 1'b0;
      repeat (40) @(negedge clk);
      check("pre_reset_driving", int'({tx_busy, tx_oen}), 3);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", int'({dp_tx, dn_tx, tx_oen, tx_ready, tx_busy}), 5'b10000);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (tx_oen || tx_busy || !dp_tx || dn_tx) cnt++;
      end
      check("no_eop_after_reset", cnt, 0);

      run_vec(vecs[0], 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
